// File: rtl/rx_sm_if.sv
// PHY receive byte stream in, RX frame FIFO write/commit/discard and per-frame status out.
interface rx_sm_if;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       fifo_full;
    logic [7:0] fifo_data;
    logic       fifo_data_write;
    logic       fifo_data_start;
    logic       fifo_commit;
    logic       fifo_discard;
    logic       frame_good;
    logic       frame_bad;
    logic       crc_error;
    logic       length_error;
    logic       overflow;

    modport master (
        output rx_data_valid, rx_data, rx_error, fifo_full,
        input  fifo_data, fifo_data_write, fifo_data_start, fifo_commit, fifo_discard,
        input  frame_good, frame_bad, crc_error, length_error, overflow
    );

    modport slave (
        input  rx_data_valid, rx_data, rx_error, fifo_full,
        output fifo_data, fifo_data_write, fifo_data_start, fifo_commit, fifo_discard,
        output frame_good, frame_bad, crc_error, length_error, overflow
    );
endinterface

// File: rtl/rx_sm.sv
// Ethernet MAC receive FSM: strips preamble/SFD, writes DA..payload to the FIFO 4 bytes behind the PHY,
// checks FCS and length; fifo_full on a write drops the frame (no stall), verdict 1 cycle after valid falls.
module rx_sm #(
    parameter int          MIN_FRAME      = 64,
    parameter int          MAX_FRAME      = 1518,
    parameter logic [31:0] CRC_POLYNOMIAL = 32'h04C11DB7,
    parameter logic [31:0] CRC_SEED       = 32'hFFFFFFFF
) (
    input  logic clock,
    input  logic reset,
    rx_sm_if.slave bus
);
    localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_L = 11'(MAX_FRAME);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] dline, dline_nx;
    logic [2:0]  held, held_nx;
    logic [10:0] byte_count, count_nx;
    logic [31:0] crc, crc_nx;
    logic        started, started_nx;
    logic        no_report, no_report_nx;
    logic        ovf_flag, ovf_nx;
    logic        len_flag, len_nx;

    logic [7:0]  data_q, data_nx;
    logic        wr_q, wr_nx, start_q, start_nx;
    logic        commit_q, commit_nx, discard_q, discard_nx;
    logic        good_q, good_nx, bad_q, bad_nx;
    logic        crc_err_q, crc_err_nx, len_err_q, len_err_nx, ovf_q, ovf_out_nx;

    logic        crc_ok, in_range, frame_ok;

    // MSB-first CRC over one byte, data bit 7 first; no reflection, no final inversion.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLYNOMIAL;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // The delay line holds the last four bytes; at frame end those are the FCS, oldest in [31:24].
    assign crc_ok   = (held == 3'd4) && (crc == dline);
    assign in_range = (byte_count >= MIN_L) && (byte_count <= MAX_L);
    assign frame_ok = crc_ok && in_range && !ovf_flag && !len_flag;

    always_comb begin
        state_nx     = state;
        dline_nx     = dline;
        held_nx      = held;
        count_nx     = byte_count;
        crc_nx       = crc;
        started_nx   = started;
        no_report_nx = no_report;
        ovf_nx       = ovf_flag;
        len_nx       = len_flag;
        data_nx      = 8'h00;
        wr_nx        = 1'b0;
        start_nx     = 1'b0;
        commit_nx    = 1'b0;
        discard_nx   = 1'b0;
        good_nx      = 1'b0;
        bad_nx       = 1'b0;
        crc_err_nx   = 1'b0;
        len_err_nx   = 1'b0;
        ovf_out_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_data_valid) begin
                    started_nx   = 1'b0;
                    ovf_nx       = 1'b0;
                    len_nx       = 1'b0;
                    held_nx      = 3'd0;
                    count_nx     = 11'd0;
                    no_report_nx = (bus.rx_data != 8'h55);
                    state_nx     = (bus.rx_data == 8'h55) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!bus.rx_data_valid) begin
                    state_nx = IDLE;
                end else if (bus.rx_data == 8'hD5) begin
                    crc_nx   = CRC_SEED;
                    state_nx = DATA;
                end else if (bus.rx_data != 8'h55) begin
                    no_report_nx = 1'b1;
                    state_nx     = DROP;
                end
            end
            DATA: begin
                if (!bus.rx_data_valid) begin
                    state_nx = DONE;
                end else if (bus.rx_error || (held == 3'd4 && bus.fifo_full)) begin
                    ovf_nx   = 1'b1;
                    state_nx = DROP;
                end else begin
                    dline_nx = {dline[23:0], bus.rx_data};
                    if (held != 3'd4)         held_nx  = held + 3'd1;
                    if (byte_count != 11'h7FF) count_nx = byte_count + 11'd1;
                    if (held == 3'd4) begin
                        data_nx    = dline[31:24];
                        wr_nx      = 1'b1;
                        start_nx   = !started;
                        started_nx = 1'b1;
                        crc_nx     = crc_byte(crc, dline[31:24]);
                    end
                    if (count_nx > MAX_L) begin
                        len_nx   = 1'b1;
                        state_nx = DROP;
                    end
                end
            end
            DROP: begin
                if (!bus.rx_data_valid) state_nx = no_report ? IDLE : DONE;
            end
            DONE: begin
                state_nx = IDLE;
                if (frame_ok) begin
                    commit_nx = 1'b1;
                    good_nx   = 1'b1;
                end else begin
                    bad_nx     = 1'b1;
                    discard_nx = started;
                    ovf_out_nx = ovf_flag;
                    crc_err_nx = !crc_ok && !ovf_flag;
                    len_err_nx = len_flag || (!in_range && !ovf_flag);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            dline      <= '0;
            held       <= '0;
            byte_count <= '0;
            crc        <= '0;
            started    <= 1'b0;
            no_report  <= 1'b0;
            ovf_flag   <= 1'b0;
            len_flag   <= 1'b0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            start_q    <= 1'b0;
            commit_q   <= 1'b0;
            discard_q  <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            crc_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            dline      <= dline_nx;
            held       <= held_nx;
            byte_count <= count_nx;
            crc        <= crc_nx;
            started    <= started_nx;
            no_report  <= no_report_nx;
            ovf_flag   <= ovf_nx;
            len_flag   <= len_nx;
            data_q     <= data_nx;
            wr_q       <= wr_nx;
            start_q    <= start_nx;
            commit_q   <= commit_nx;
            discard_q  <= discard_nx;
            good_q     <= good_nx;
            bad_q      <= bad_nx;
            crc_err_q  <= crc_err_nx;
            len_err_q  <= len_err_nx;
            ovf_q      <= ovf_out_nx;
        end
    end

    assign bus.fifo_data       = data_q;
    assign bus.fifo_data_write = wr_q;
    assign bus.fifo_data_start = start_q;
    assign bus.fifo_commit     = commit_q;
    assign bus.fifo_discard    = discard_q;
    assign bus.frame_good      = good_q;
    assign bus.frame_bad       = bad_q;
    assign bus.crc_error       = crc_err_q;
    assign bus.length_error    = len_err_q;
    assign bus.overflow        = ovf_q;
endmodule
